// File: rtl/systolic_mxn_pkg.sv
// Shared definitions for the parametrised systolic matmul array.
package systolic_mxn_pkg;

    // Tile engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // One extra bit lets unsigned operands pass through a signed multiplier
    localparam int unsigned EXT_BITS = 32'd1;

    function automatic int unsigned ext_width(input int unsigned dw);
        return dw + EXT_BITS;
    endfunction

endpackage

// File: rtl/systolic_array_mxn_pe_mac.sv
// Processing element: forwards north/west operands one hop and
// accumulates their product when both carry a valid beat.
module pe_mac
    import systolic_mxn_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_i,
    input  logic                   freeze_i,
    input  logic                   signed_mode_i,
    input  logic [DATA_WIDTH-1:0]  a_i,
    input  logic                   a_vld_i,
    input  logic [DATA_WIDTH-1:0]  b_i,
    input  logic                   b_vld_i,
    output logic [DATA_WIDTH-1:0]  a_o,
    output logic                   a_vld_o,
    output logic [DATA_WIDTH-1:0]  b_o,
    output logic                   b_vld_o,
    output logic [ACCUM_WIDTH-1:0] acc_o
);
    localparam int EW = int'(ext_width(DATA_WIDTH));

    logic signed [EW-1:0]          a_ext_s;
    logic signed [EW-1:0]          b_ext_s;
    logic signed [2*EW-1:0]        prod_s;
    logic [ACCUM_WIDTH-1:0]        acc_d;
    logic [DATA_WIDTH-1:0]         a_q;
    logic [DATA_WIDTH-1:0]         b_q;
    logic                          a_vld_q;
    logic                          b_vld_q;
    logic [ACCUM_WIDTH-1:0]        acc_q;

    assign a_ext_s = signed_mode_i ? {a_i[DATA_WIDTH-1], a_i} : {1'b0, a_i};
    assign b_ext_s = signed_mode_i ? {b_i[DATA_WIDTH-1], b_i} : {1'b0, b_i};
    assign prod_s  = (2*EW)'(a_ext_s) * (2*EW)'(b_ext_s);
    assign acc_d   = acc_q + ACCUM_WIDTH'(prod_s);

    // Operand hop registers and the accumulator (clear beats MAC, freeze holds)
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            a_vld_q <= 1'b0;
            b_vld_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            a_q     <= a_i;
            b_q     <= b_i;
            a_vld_q <= a_vld_i;
            b_vld_q <= b_vld_i;
            if (clear_i) begin
                acc_q <= '0;
            end else if (!freeze_i && a_vld_i && b_vld_i) begin
                acc_q <= acc_d;
            end else begin
                acc_q <= acc_q;
            end
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign a_vld_o = a_vld_q;
    assign b_vld_o = b_vld_q;
    assign acc_o   = acc_q;

endmodule

// File: rtl/systolic_array_mxn.sv
// ROWS x COLS systolic matmul tile engine: skews operand lanes, runs
// LOAD/FLUSH/DRAIN sequencing and drains results one row per handshake.
module systolic_array_mxn
    import systolic_mxn_pkg::*;
#(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int ACCUM_WIDTH = 32,
    parameter int KW          = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [KW-1:0]                 k_len,
    input  logic                          signed_mode,
    input  logic                          accumulate,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0]    a_data,
    input  logic [COLS*DATA_WIDTH-1:0]    b_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COLS*ACCUM_WIDTH-1:0]   out_data,
    output logic [$clog2(ROWS)-1:0]       out_row,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);
    localparam int RW = $clog2(ROWS);
    localparam int FW = $clog2(ROWS + COLS);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ACCUM_WIDTH;

    state_e                  state_q;
    logic [KW-1:0]           k_len_q;
    logic [KW-1:0]           beat_q;
    logic [FW-1:0]           flush_q;
    logic                    sgn_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [RW-1:0]           out_row_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    done_q;
    logic [COLS*AW-1:0]      out_data_q;

    logic                    beat_acc_s;
    logic                    clr_acc_s;
    logic                    freeze_s;
    logic [RW-1:0]           row_nxt_s;
    logic [RW-1:0]           row_sel_s;
    logic [COLS*AW-1:0]      row_data_s;

    logic [DW-1:0]           a_w  [ROWS][COLS+1];
    logic                    a_wv [ROWS][COLS+1];
    logic [DW-1:0]           b_w  [ROWS+1][COLS];
    logic                    b_wv [ROWS+1][COLS];
    logic [AW-1:0]           acc_w [ROWS][COLS];

    assign beat_acc_s = in_valid & in_ready_q;
    assign clr_acc_s  = (state_q == ST_IDLE) & start & ~accumulate;
    assign freeze_s   = (state_q == ST_DRAIN);
    assign row_nxt_s  = out_row_q + RW'(1);
    assign row_sel_s  = (state_q == ST_DRAIN) ? row_nxt_s : RW'(0);

    // Input skew: lane r of A delayed r+1 cycles, invalid beats enter as zero
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DW:0] pipe_q [r+1];
        // Delay line for A lane r
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= beat_acc_s ? {1'b1, a_data[r*DW +: DW]} : '0;
                for (int i = 1; i <= r; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign a_w[r][0]  = pipe_q[r][DW-1:0];
        assign a_wv[r][0] = pipe_q[r][DW];
    end

    // Input skew: lane c of B delayed c+1 cycles
    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DW:0] pipe_q [c+1];
        // Delay line for B lane c
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= c; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= beat_acc_s ? {1'b1, b_data[c*DW +: DW]} : '0;
                for (int i = 1; i <= c; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign b_w[0][c]  = pipe_q[c][DW-1:0];
        assign b_wv[0][c] = pipe_q[c][DW];
    end

    // PE grid: A flows east, B flows south
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            pe_mac #(.DATA_WIDTH(DW), .ACCUM_WIDTH(AW)) u_pe (
                .clk           (clk),
                .rst           (rst),
                .clear_i       (clr_acc_s),
                .freeze_i      (freeze_s),
                .signed_mode_i (sgn_q),
                .a_i           (a_w[r][c]),
                .a_vld_i       (a_wv[r][c]),
                .b_i           (b_w[r][c]),
                .b_vld_i       (b_wv[r][c]),
                .a_o           (a_w[r][c+1]),
                .a_vld_o       (a_wv[r][c+1]),
                .b_o           (b_w[r+1][c]),
                .b_vld_o       (b_wv[r+1][c]),
                .acc_o         (acc_w[r][c])
            );
        end
    end

    // Row-select mux feeding the drain register
    always_comb begin
        row_data_s = '0;
        for (int c = 0; c < COLS; c++) begin
            row_data_s[c*AW +: AW] = acc_w[row_sel_s][c];
        end
    end

    // Tile sequencer with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_len_q     <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            sgn_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        k_len_q <= k_len;
                        sgn_q   <= signed_mode;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                        if (k_len == KW'(0)) begin
                            state_q <= ST_FLUSH;
                            flush_q <= FW'(ROWS + COLS - 1);
                        end else begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (beat_acc_s) begin
                        beat_q <= beat_q + KW'(1);
                        if (beat_q == k_len_q - KW'(1)) begin
                            state_q    <= ST_FLUSH;
                            in_ready_q <= 1'b0;
                            flush_q    <= FW'(ROWS + COLS - 1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_q == FW'(0)) begin
                        state_q     <= ST_DRAIN;
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_last_q  <= 1'b0;
                        out_data_q  <= row_data_s;
                    end else begin
                        flush_q <= flush_q - FW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            out_row_q  <= row_nxt_s;
                            out_last_q <= (row_nxt_s == RW'(ROWS - 1));
                            out_data_q <= row_data_s;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
